loc_max_tree: RTL

- Pipelined 64-input signed max-reduction tree; sits directly upstream of the global-max forwarding stage.
- Per beat, takes 64 signed 16-bit elements on a 1024-bit bus and produces:
  - the beat-local max (feeds the accumulator as loc_max);
  - the partial maxima: 1x64, 2x32, 4x16 element segments.
- Also produces delayed bypass copies of valid, length mode and raw data, all aligned to the maxima.

---
 rtl/loc_max_tree_if.sv | 32 +++
 rtl/loc_max_tree.sv | 138 +++++++++++++
 2 files changed

// File: rtl/loc_max_tree_if.sv
// Beat bus for the 64-input signed max tree: input beat, pipeline enable and aligned outputs.
// master drives the beat and enable; slave (the tree) drives the maxima and bypass copies.
interface loc_max_tree_if;
    logic          i_en;
    logic          i_valid;
    logic [3:0]    i_length_mode;
    logic [1023:0] i_in_flat;

    logic          o_valid_max;
    logic [15:0]   o_loc_max;
    logic [3:0]    o_length_mode_byp;
    logic [1023:0] o_in_byp;
    logic [15:0]   o_max64_0;
    logic [15:0]   o_max32_0;
    logic [15:0]   o_max32_1;
    logic [15:0]   o_max16_0;
    logic [15:0]   o_max16_1;
    logic [15:0]   o_max16_2;
    logic [15:0]   o_max16_3;

    modport master (
        output i_en, i_valid, i_length_mode, i_in_flat,
        input  o_valid_max, o_loc_max, o_length_mode_byp, o_in_byp, o_max64_0,
               o_max32_0, o_max32_1, o_max16_0, o_max16_1, o_max16_2, o_max16_3
    );

    modport slave (
        input  i_en, i_valid, i_length_mode, i_in_flat,
        output o_valid_max, o_loc_max, o_length_mode_byp, o_in_byp, o_max64_0,
               o_max32_0, o_max32_1, o_max16_0, o_max16_1, o_max16_2, o_max16_3
    );
endinterface

// File: rtl/loc_max_tree.sv
// Pipelined 64x16b signed max tree with 16/32/64-segment partial maxima; latency 3 enabled cycles.
// No backpressure: i_en=0 freezes every stage (data and valid), one beat per enabled cycle.
module loc_max_tree #(
    parameter int DATA_W = 16,
    parameter int N_ELEM = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    loc_max_tree_if.slave  bus
);

    localparam int FLAT_W = DATA_W * N_ELEM;
    localparam int N_L1   = N_ELEM / 2;
    localparam int N_MAX4 = N_ELEM / 4;
    localparam int N_L3   = N_ELEM / 8;
    localparam int N_MX16 = N_ELEM / 16;

    typedef logic signed [DATA_W-1:0] elem_t;

    // Most negative value: identity for max, and the reset value of every max register.
    localparam elem_t MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic elem_t smax(input elem_t a, input elem_t b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- combinational levels ----------------
    elem_t l1      [N_L1];
    elem_t max4_d  [N_MAX4];
    elem_t l3      [N_L3];
    elem_t max16_d [N_MX16];

    elem_t max4_q  [N_MAX4];
    elem_t max16_q [N_MX16];

    elem_t m16_d [N_MX16];
    elem_t m16_q [N_MX16];
    elem_t m32_d [2];
    elem_t m32_q [2];
    elem_t m64_d;
    elem_t m64_q;

    logic [2:0]        vld_d;
    logic [2:0]        vld_q;
    logic [3:0]        mode_d [3];
    logic [3:0]        mode_q [3];
    logic [FLAT_W-1:0] data_d [3];
    logic [FLAT_W-1:0] data_q [3];

    // L1 + L2: adjacent pairs, then pairs of pairs, feeding S1.
    always_comb begin
        for (int k = 0; k < N_L1; k++) begin
            l1[k] = smax(elem_t'(bus.i_in_flat[DATA_W*(2*k)   +: DATA_W]),
                         elem_t'(bus.i_in_flat[DATA_W*(2*k+1) +: DATA_W]));
        end
        for (int k = 0; k < N_MAX4; k++) begin
            max4_d[k] = smax(l1[2*k], l1[2*k+1]);
        end
    end

    // L3 + L4 from the registered max4 values, feeding S2.
    always_comb begin
        for (int k = 0; k < N_L3; k++) begin
            l3[k] = smax(max4_q[2*k], max4_q[2*k+1]);
        end
        for (int k = 0; k < N_MX16; k++) begin
            max16_d[k] = smax(l3[2*k], l3[2*k+1]);
        end
    end

    // L5 + L6 from S2, feeding S3 alongside the copied max16 values.
    always_comb begin
        for (int k = 0; k < N_MX16; k++) begin
            m16_d[k] = max16_q[k];
        end
        m32_d[0] = smax(max16_q[0], max16_q[1]);
        m32_d[1] = smax(max16_q[2], max16_q[3]);
        m64_d    = smax(m32_d[0], m32_d[1]);
    end

    // Sideband shift registers stay in lockstep with S1..S3.
    always_comb begin
        vld_d     = {vld_q[1:0], bus.i_valid};
        mode_d[0] = bus.i_length_mode;
        data_d[0] = bus.i_in_flat;
        for (int s = 1; s < 3; s++) begin
            mode_d[s] = mode_q[s-1];
            data_d[s] = data_q[s-1];
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_MAX4; k++) max4_q[k] <= MIN_VAL;
            for (int k = 0; k < N_MX16; k++) begin
                max16_q[k] <= MIN_VAL;
                m16_q[k]   <= MIN_VAL;
            end
            m32_q[0] <= MIN_VAL;
            m32_q[1] <= MIN_VAL;
            m64_q    <= MIN_VAL;
            vld_q    <= '0;
            for (int s = 0; s < 3; s++) begin
                mode_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else if (bus.i_en) begin
            for (int k = 0; k < N_MAX4; k++) max4_q[k] <= max4_d[k];
            for (int k = 0; k < N_MX16; k++) begin
                max16_q[k] <= max16_d[k];
                m16_q[k]   <= m16_d[k];
            end
            m32_q[0] <= m32_d[0];
            m32_q[1] <= m32_d[1];
            m64_q    <= m64_d;
            vld_q    <= vld_d;
            for (int s = 0; s < 3; s++) begin
                mode_q[s] <= mode_d[s];
                data_q[s] <= data_d[s];
            end
        end
    end

    // ---------------- outputs, straight from S3 ----------------
    assign bus.o_valid_max       = vld_q[2];
    assign bus.o_length_mode_byp = mode_q[2];
    assign bus.o_in_byp          = data_q[2];
    assign bus.o_loc_max         = m64_q;
    assign bus.o_max64_0         = m64_q;
    assign bus.o_max32_0         = m32_q[0];
    assign bus.o_max32_1         = m32_q[1];
    assign bus.o_max16_0         = m16_q[0];
    assign bus.o_max16_1         = m16_q[1];
    assign bus.o_max16_2         = m16_q[2];
    assign bus.o_max16_3         = m16_q[3];

endmodule
